// File: rtl/addsub_pkg.sv
// Shared types and helpers for the multi-cycle adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width of the chunk index; at least one bit so a single-chunk build still has a counter.
  function automatic int unsigned chunk_idx_w(input int unsigned w, input int unsigned d);
    int unsigned n;
    n = w / d;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// Combinational D-bit ripple-carry slice built from per-bit full-adder equations.
module addsub_slice #(
  parameter int unsigned D = 4
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         cin,
  output logic [D-1:0] s,
  output logic         cout
);

  logic [D:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < D; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

  assign cout = c[D];

endmodule

// File: rtl/addsub_multicycle.sv
// W-bit two's-complement add/sub evaluated D bits per clock through one shared ripple slice.
// Optional saturation on signed overflow: define ADDSUB_SAT_EN.
module addsub_multicycle
  import addsub_pkg::*;
#(
  parameter int unsigned W = 16,
  parameter int unsigned D = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] R,
  output logic         ovf,
  output logic         cout,
  output logic         zero
);

  localparam int unsigned N  = W / D;
  localparam int unsigned KW = chunk_idx_w(W, D);

  generate
    if ((W % D) != 0) begin : g_bad_width
      $error("addsub_multicycle: W must be a multiple of D");
    end
  endgenerate

  state_e        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  bx_q, bx_d;
  logic          carry_q, carry_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  r_q, r_d;
  logic          ovf_q, ovf_d;
  logic          cout_q, cout_d;
  logic          zero_q, zero_d;

  logic [D-1:0]  slice_a, slice_b, slice_s;
  logic          slice_c;
  logic [W-1:0]  sum;
  logic          ovf_v;

  addsub_slice #(.D(D)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .s    (slice_s),
    .cout (slice_c)
  );

  always_comb begin
    slice_a = '0;
    slice_b = '0;
    sum     = acc_q;
    for (int unsigned i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        slice_a          = a_q[i*D +: D];
        slice_b          = bx_q[i*D +: D];
        sum[i*D +: D]    = slice_s;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bx_d    = bx_q;
    carry_d = carry_q;
    k_d     = k_q;
    acc_d   = acc_q;
    r_d     = r_q;
    ovf_d   = ovf_q;
    cout_d  = cout_q;
    zero_d  = zero_q;
    ovf_v   = (a_q[W-1] & bx_q[W-1] & ~sum[W-1]) | (~a_q[W-1] & ~bx_q[W-1] & sum[W-1]);

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = A;
          bx_d    = B ^ {W{sub}};
          carry_d = sub;
          k_d     = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_d   = sum;
        carry_d = slice_c;
        k_d     = k_q + 1'b1;
        // Result and flags are published only on the last slice, so R never shows partial sums.
        if (k_q == KW'(N - 1)) begin
          state_d = ST_DONE;
          r_d     = sum;
`ifdef ADDSUB_SAT_EN
          if (ovf_v) begin
            r_d = a_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end
`else
`endif
          ovf_d  = ovf_v;
          cout_d = slice_c;
          zero_d = (r_d == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      bx_q    <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      acc_q   <= '0;
      r_q     <= '0;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bx_q    <= bx_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      ovf_q   <= ovf_d;
      cout_q  <= cout_d;
      zero_q  <= zero_d;
    end
  end

  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign R     = r_q;
  assign ovf   = ovf_q;
  assign cout  = cout_q;
  assign zero  = zero_q;

endmodule

// File: tb/tb_addsub_multicycle.sv
// Directed self-checking bench for addsub_multicycle (W=16, D=4); honours ADDSUB_SAT_EN.
module tb_addsub_multicycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a_in, b_in;
  logic        ready, busy, done, ovf, cout, zero;
  logic [15:0] r_out;

  int checks = 0;
  int errors = 0;

  addsub_multicycle #(.W(16), .D(4)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sub   (sub),
    .A     (a_in),
    .B     (b_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .R     (r_out),
    .ovf   (ovf),
    .cout  (cout),
    .zero  (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic [15:0] r_wrap;
    logic [15:0] r_sat;
    logic        ovf;
    logic        cout;
    logic        zero;
  } vec_t;

  // Pulse start for one edge, then count edges until done (-1 if it never comes).
  task automatic issue_and_wait(input logic [15:0] a, input logic [15:0] b, input logic s,
                                output int lat);
    a_in = a; b_in = b; sub = s; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (done) break;
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (r_out !== 16'h0000) begin errors++; $display("FAIL reset_r got %h exp 0000", r_out); end
    checks++; if ({ovf, cout} !== 2'b00) begin errors++; $display("FAIL reset_flags got ovf=%b cout=%b exp 0 0", ovf, cout); end
    checks++; if (zero !== 1'b1) begin errors++; $display("FAIL reset_zero got %b exp 1", zero); end
  endtask

  task automatic test_arith();
    vec_t v[6];
    int lat;
    logic [15:0] exp_r;
    v[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 16'h2233, 1'b0, 1'b0, 1'b0};
    v[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b0};
    v[2] = '{16'h8000, 16'h0001, 1'b1, 16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0};
    v[3] = '{16'h0003, 16'h0005, 1'b1, 16'hFFFE, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    v[4] = '{16'h0005, 16'h0005, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
    v[5] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
`ifdef ADDSUB_SAT_EN
      exp_r = v[i].r_sat;
`else
      exp_r = v[i].r_wrap;
`endif
      issue_and_wait(v[i].a, v[i].b, v[i].s, lat);
      checks++; if (lat !== 4) begin errors++; $display("FAIL arith%0d_latency got %0d exp 4", i, lat); end
      checks++; if (r_out !== exp_r) begin errors++; $display("FAIL arith%0d_r got %h exp %h", i, r_out, exp_r); end
      checks++; if (ovf !== v[i].ovf) begin errors++; $display("FAIL arith%0d_ovf got %b exp %b", i, ovf, v[i].ovf); end
      checks++; if (cout !== v[i].cout) begin errors++; $display("FAIL arith%0d_cout got %b exp %b", i, cout, v[i].cout); end
      checks++; if (zero !== v[i].zero) begin errors++; $display("FAIL arith%0d_zero got %b exp %b", i, zero, v[i].zero); end
      @(posedge clk); #1;
      checks++; if (done !== 1'b0 || ready !== 1'b1) begin errors++; $display("FAIL arith%0d_pulse got done=%b ready=%b exp 0 1", i, done, ready); end
    end
  endtask

  // Previous R from test_arith is 0x0000; prime with a known nonzero result first.
  task automatic test_handshake();
    int lat;
    issue_and_wait(16'h0100, 16'h0023, 1'b0, lat);
    checks++; if (r_out !== 16'h0123) begin errors++; $display("FAIL hs_prime_r got %h exp 0123", r_out); end
    a_in = 16'h1111; b_in = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b1 || ready !== 1'b0) begin errors++; $display("FAIL hs_busy got busy=%b ready=%b exp 1 0", busy, ready); end
    checks++; if (r_out !== 16'h0123) begin errors++; $display("FAIL hs_r_hold got %h exp 0123", r_out); end
    a_in = 16'hFFFF; b_in = 16'h0000; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 2;
    while (lat < 20 && !done) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 4) begin errors++; $display("FAIL hs_latency got %0d exp 4", lat); end
    checks++; if (r_out !== 16'h2222) begin errors++; $display("FAIL hs_r got %h exp 2222", r_out); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0 || r_out !== 16'h2222) begin
      errors++; $display("FAIL hs_after got busy=%b done=%b r=%h exp 0 0 2222", busy, done, r_out);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, d1, d2, ndone;
    logic [15:0] r1, r2;
    d1 = -1; d2 = -1; ndone = 0; r1 = 'x; r2 = 'x;
    a_in = 16'h0001; b_in = 16'h0002; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a_in = 16'h0010; b_in = 16'h0020;
    for (cyc = 1; cyc <= 30 && ndone < 2; cyc++) begin
      @(posedge clk); #1;
      if (done) begin
        if (ndone == 0) begin d1 = cyc; r1 = r_out; end
        else begin d2 = cyc; r2 = r_out; end
        ndone++;
      end
    end
    start = 1'b0;
    checks++; if (d1 !== 4) begin errors++; $display("FAIL b2b_first_done got %0d exp 4", d1); end
    checks++; if (d2 - d1 !== 5) begin errors++; $display("FAIL b2b_spacing got %0d exp 5", d2 - d1); end
    checks++; if (r1 !== 16'h0003) begin errors++; $display("FAIL b2b_r1 got %h exp 0003", r1); end
    checks++; if (r2 !== 16'h0030) begin errors++; $display("FAIL b2b_r2 got %h exp 0030", r2); end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_abort();
    int lat;
    int seen;
    seen = 0;
    a_in = 16'h1234; b_in = 16'h1111; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++; if (ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL abort_state got ready=%b busy=%b exp 1 0", ready, busy); end
    checks++; if (r_out !== 16'h0000 || zero !== 1'b1) begin errors++; $display("FAIL abort_r got r=%h zero=%b exp 0000 1", r_out, zero); end
    for (int i = 0; i < 6; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL abort_no_done got %0d pulses exp 0", seen); end
    issue_and_wait(16'h0002, 16'h0003, 1'b0, lat);
    checks++; if (lat !== 4 || r_out !== 16'h0005) begin errors++; $display("FAIL abort_fresh got lat=%0d r=%h exp 4 0005", lat, r_out); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sub = 1'b0; a_in = '0; b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    test_arith();
    test_handshake();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
